motor_plant_model: RTL and testbench

MOTOR_PLANT_MODEL -- requirements
Module: motor_plant_model

---
 rtl/motor_plant_model.sv | 103 ++++++++++
 tb/tb_motor_plant_model.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_plant_model.sv
// First-order lag model of four motors: every TICK_DIV cycles each rpm_sense
// moves 1/2^SHIFT of the way toward its command, with a settle detector.
module motor_plant_model #(
  parameter int TICK_DIV     = 4,
  parameter int SHIFT        = 3,
  parameter int TOL          = 16,
  parameter int SETTLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0][15:0] mot_set,
  input  logic             set,
  input  logic [3:0][15:0] rpm_sense_set,
  output logic [3:0][15:0] rpm_sense,
  output logic             tick,
  output logic             settled,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [7:0]  TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_TICKS);
  localparam logic [16:0] TOL_W      = 17'(TOL);

  state_e           state_q, state_d;
  logic [3:0][15:0] rpm_q, rpm_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             tick_q, tick_d;

  logic signed [16:0] err  [4];
  logic signed [16:0] step [4];
  logic        [16:0] mag  [4];
  logic [3:0][15:0]   rpm_upd;
  logic               all_in_tol;

  // Plant arithmetic for all motors; only consumed on update edges.
  always_comb begin
    all_in_tol = 1'b1;
    rpm_upd    = '0;
    for (int i = 0; i < 4; i++) begin
      err[i]  = $signed({mot_set[i][15], mot_set[i]}) - $signed({rpm_q[i][15], rpm_q[i]});
      step[i] = err[i] >>> SHIFT;
      // The new value lies between old rpm and the command, so it always fits 16 bits.
      rpm_upd[i] = 16'($signed({rpm_q[i][15], rpm_q[i]}) + step[i]);
      mag[i]  = err[i][16] ? 17'(-err[i]) : 17'(err[i]);
      if (mag[i] > TOL_W) all_in_tol = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    rpm_d      = rpm_q;
    tick_cnt_d = tick_cnt_q;
    settle_d   = settle_q;
    tick_d     = 1'b0;
    if (set) begin
      state_d    = HOLD;
      rpm_d      = rpm_sense_set;
      tick_cnt_d = '0;
      settle_d   = '0;
    end else if (state_q != IDLE) begin
      // The edge leaving HOLD already counts toward the first update.
      state_d = RUN;
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
        rpm_d      = rpm_upd;
        if (!all_in_tol)                settle_d = '0;
        else if (settle_q != SETTLE_MAX) settle_d = settle_q + 8'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rpm_q      <= '0;
      tick_cnt_q <= '0;
      settle_q   <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rpm_q      <= rpm_d;
      tick_cnt_q <= tick_cnt_d;
      settle_q   <= settle_d;
      tick_q     <= tick_d;
    end
  end

  assign rpm_sense = rpm_q;
  assign tick      = tick_q;
  assign settled   = (settle_q == SETTLE_MAX);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_plant_model.sv
// Directed bench for motor_plant_model at default parameters
// (TICK_DIV=4, SHIFT=3, TOL=16, SETTLE_TICKS=8).
module tb_motor_plant_model;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][15:0] mot_set;
  logic             set;
  logic [3:0][15:0] rpm_sense_set;
  logic [3:0][15:0] rpm_sense;
  logic             tick;
  logic             settled;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;

  motor_plant_model dut (
    .clk           (clk),
    .reset         (reset),
    .mot_set       (mot_set),
    .set           (set),
    .rpm_sense_set (rpm_sense_set),
    .rpm_sense     (rpm_sense),
    .tick          (tick),
    .settled       (settled),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it for sampling/driving.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_mot(input logic [15:0] v);
    for (int i = 0; i < 4; i++) mot_set[i] = v;
  endtask

  task automatic set_all_load(input logic [15:0] v);
    for (int i = 0; i < 4; i++) rpm_sense_set[i] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set   = 1'b0;
    set_all_mot(16'd800);
    set_all_load(16'd0);
    #12;
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (rpm_sense[m] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_rpm motor %0d: got %0d want 0", m, $signed(rpm_sense[m]));
      end
    end
    n_checks++;
    if (tick !== 1'b0 || settled !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_flags: tick=%b settled=%b state=%0d want 0 0 0", tick, settled, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    // IDLE with set low: no dynamics even with a nonzero command.
    repeat (6) step_clk();
    n_checks++;
    if (rpm_sense[0] !== 16'd0 || tick !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL idle_hold: rpm=%0d tick=%b state=%0d want 0 0 0", $signed(rpm_sense[0]), tick, dbg_state);
    end
  endtask

  task automatic test_step_response();
    logic [15:0] exp_rpm;
    set_all_load(16'd0);
    set = 1'b1;
    repeat (10) step_clk();
    set_all_mot(16'd800);
    set = 1'b0;
    // 800>>>3=100; (800-100)>>>3=87 -> 187; (800-187)>>>3=76 -> 263
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      exp_rpm = (k < 4) ? 16'd0 : (k < 8) ? 16'd100 : (k < 12) ? 16'd187 : 16'd263;
      for (int m = 0; m < 4; m++) begin
        n_checks++;
        if (rpm_sense[m] !== exp_rpm) begin
          n_fail++;
          $display("FAIL step_rpm edge %0d motor %0d: got %0d want %0d", k, m, $signed(rpm_sense[m]), exp_rpm);
        end
      end
      n_checks++;
      if (tick !== ((k % 4) == 0)) begin
        n_fail++;
        $display("FAIL step_tick edge %0d: got %b want %b", k, tick, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_negative_approach();
    int exp_v;
    set_all_load(16'd0);
    set_all_mot(16'hFFF8);
    set = 1'b1;
    step_clk();
    set = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      repeat (4) step_clk();
      exp_v = (t < 8) ? -t : -8;
      n_checks++;
      if ($signed(rpm_sense[2]) !== 16'(exp_v) || tick !== 1'b1) begin
        n_fail++;
        $display("FAIL neg_approach tick %0d: rpm=%0d tick=%b want %0d 1", t, $signed(rpm_sense[2]), tick, exp_v);
      end
    end
  endtask

  task automatic test_positive_offset();
    set_all_load(16'd0);
    set_all_mot(16'd7);
    set = 1'b1;
    step_clk();
    set = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      repeat (4) step_clk();
      n_checks++;
      if (rpm_sense[1] !== 16'd0 || settled !== (t >= 8)) begin
        n_fail++;
        $display("FAIL pos_offset tick %0d: rpm=%0d settled=%b want 0 %b", t, $signed(rpm_sense[1]), settled, t >= 8);
      end
    end
  endtask

  // Runs straight after the offset test: RUN, tick counter at 0, settled high.
  task automatic test_set_mid_run();
    repeat (2) step_clk();
    set_all_mot(16'd800);
    set_all_load(16'd500);
    set = 1'b1;
    step_clk();
    set = 1'b0;
    n_checks++;
    if (rpm_sense[3] !== 16'd500 || tick !== 1'b0 || settled !== 1'b0 || dbg_state !== S_HOLD) begin
      n_fail++;
      $display("FAIL set_mid_load: rpm=%0d tick=%b settled=%b state=%0d want 500 0 0 1",
               $signed(rpm_sense[3]), tick, settled, dbg_state);
    end
    repeat (3) step_clk();
    n_checks++;
    if (rpm_sense[3] !== 16'd500 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL set_mid_wait: rpm=%0d tick=%b want 500 0", $signed(rpm_sense[3]), tick);
    end
    step_clk();
    // 500 + (300>>>3) = 537
    n_checks++;
    if (rpm_sense[3] !== 16'd537 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL set_mid_update: rpm=%0d tick=%b want 537 1", $signed(rpm_sense[3]), tick);
    end
  endtask

  // Entered 1ns after an update edge, so tick is high and rpm is nonzero.
  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rpm_sense !== '0 || tick !== 1'b0 || settled !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL async_reset: rpm0=%0d tick=%b settled=%b state=%0d want 0 0 0 0",
               $signed(rpm_sense[0]), tick, settled, dbg_state);
    end
    #1;
    reset = 1'b0;
    repeat (9) step_clk();
    n_checks++;
    if (rpm_sense !== '0 || tick !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL post_reset_idle: rpm0=%0d tick=%b state=%0d want 0 0 0", $signed(rpm_sense[0]), tick, dbg_state);
    end
  endtask

  task automatic test_per_motor();
    logic [15:0] exp_v [4];
    rpm_sense_set[0] = 16'd10;   mot_set[0] = 16'd100;
    rpm_sense_set[1] = -16'sd20; mot_set[1] = -16'sd100;
    rpm_sense_set[2] = 16'd30;   mot_set[2] = 16'd30;
    rpm_sense_set[3] = -16'sd40; mot_set[3] = 16'd0;
    // 10+(90>>>3)=21; -20+(-80>>>3)=-30; 30+0=30; -40+(40>>>3)=-35
    exp_v[0] = 16'd21; exp_v[1] = -16'sd30; exp_v[2] = 16'd30; exp_v[3] = -16'sd35;
    set = 1'b1;
    step_clk();
    set = 1'b0;
    n_checks++;
    if (rpm_sense !== rpm_sense_set) begin
      n_fail++;
      $display("FAIL per_motor_load: got %h want %h", rpm_sense, rpm_sense_set);
    end
    // A command change between ticks is only seen at the update edge.
    mot_set[2] = 16'd1000;
    step_clk();
    mot_set[2] = 16'd30;
    repeat (3) step_clk();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (rpm_sense[m] !== exp_v[m]) begin
        n_fail++;
        $display("FAIL per_motor_update motor %0d: got %0d want %0d", m, $signed(rpm_sense[m]), $signed(exp_v[m]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_response();
    test_negative_approach();
    test_positive_offset();
    test_set_mid_run();
    test_async_reset();
    test_per_motor();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
